reg_nbits_piso: RTL and testbench
=================================

REG_NBITS_PISO -- requirements
Module: reg_nbits_piso

Interface
REQ-001 Parameter N, default 4, word width in bits; legal range N >= 2.
REQ-002 reloj  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 carga  input  1  load strobe; captures In when the block is idle.
REQ-005 habilitar  input  1  shift enable; while low, an in-progress transfer holds.
REQ-006 In  input  N  parallel word to serialize.
REQ-007 Sout  output  1  serial data, LSB first.
REQ-008 ocupado  output  1  high while a transfer is in progress.
REQ-009 listo  output  1  one-cycle pulse marking transfer completion.

Function
REQ-010 The block SHALL hold an N-bit shift register, a bit counter of width $clog2(N+1), and a two-state FSM: IDLE and SHIFT.
REQ-011 In IDLE, a rising edge with carga=1 SHALL load In into the shift register, clear the counter, and enter SHIFT.
REQ-012 In IDLE with carga=0, register, counter and state SHALL hold.
REQ-013 In SHIFT, each rising edge with habilitar=1 SHALL shift the register right by one (MSB filled with 0) and increment the counter.
REQ-014 In SHIFT, an edge with habilitar=0 SHALL leave register, counter and state unchanged.
REQ-015 The N-th enabled shift edge after a load SHALL return the FSM to IDLE.
REQ-016 Sout SHALL equal shift-register bit 0 while in SHIFT, and 0 in IDLE (combinational from state).
REQ-017 Sout sequence after a load: In[0] in the cycle after the load edge, then In[k] after the k-th enabled shift edge, for k = 1..N-1.
REQ-018 ocupado SHALL be 1 exactly while the FSM is in SHIFT (decoded from state, no extra latency).
REQ-019 listo SHALL be a registered output, 1 for exactly one cycle after the edge that moves SHIFT to IDLE, 0 otherwise.
REQ-020 carga asserted during SHIFT SHALL be ignored; the current transfer and its data are unaffected.
REQ-021 carga=1 in the cycle listo=1 (state IDLE) SHALL be accepted, giving back-to-back transfers with exactly one idle cycle between words.
REQ-022 In changes while in SHIFT SHALL have no effect on the transfer.
REQ-023 Load-to-IDLE latency SHALL be N+1 edges when habilitar stays high (load edge plus N shift edges).

Reset
REQ-024 An edge with reset=1 SHALL set FSM to IDLE, shift register to 0, counter to 0, and listo to 0, so that Sout=0 and ocupado=0.
REQ-025 reset SHALL take priority over carga and habilitar on the same edge.
REQ-026 reset mid-transfer SHALL abort the transfer without a listo pulse; the next carga after reset starts a fresh transfer.

Verification (N=4)
REQ-027 Reset, then carga=1 with In=4'b1011 and habilitar=1 held -> ocupado=1 for 4 cycles, Sout=1,1,0,1, then ocupado=0, listo=1 for one cycle, Sout=0.
REQ-028 Same load, habilitar=0 for 3 cycles after the second bit -> Sout holds 1 for those cycles, then continues 0,1; completion is delayed by exactly 3 cycles.
REQ-029 In=4'b0110 loaded, carga=1 with In=4'b1111 pulsed during SHIFT -> Sout=0,1,1,0 unchanged, one listo pulse only.
REQ-030 carga held high continuously with In=4'b1001 -> repeating pattern 1,0,0,1 then one idle cycle (Sout=0, ocupado=0, listo=1), repeated.
REQ-031 reset=1 asserted after the second shift edge -> next cycle ocupado=0, Sout=0, no listo pulse; subsequent load of 4'b0011 yields 1,1,0,0.
REQ-032 reset=1 and carga=1 on the same edge -> block stays IDLE, ocupado=0.

Source files
------------

// File: rtl/reg_nbits_piso.sv
// reg_nbits_piso: N-bit parallel-in, serial-out shift register.
//
// A word presented on In is captured by carga while idle and then shifted out LSB first on
// Sout, one bit per enabled clock. habilitar low freezes a transfer in place. ocupado marks
// the transfer window and listo pulses for one cycle once the last bit has been consumed.
//
// Ports:
//   reloj     - clock, rising edge active
//   reset     - synchronous, active-high reset; wins over carga and habilitar
//   carga     - load strobe, honoured only while idle
//   habilitar - shift enable; low holds an in-progress transfer
//   In        - parallel word to serialize
//   Sout      - serial data out, LSB first, forced to 0 while idle
//   ocupado   - high while a transfer is in progress
//   listo     - registered one-cycle completion pulse
module reg_nbits_piso #(
  parameter int unsigned N = 4
) (
  input  logic         reloj,
  input  logic         reset,
  input  logic         carga,
  input  logic         habilitar,
  input  logic [N-1:0] In,
  output logic         Sout,
  output logic         ocupado,
  output logic         listo
);

  localparam int unsigned CntW = $clog2(N + 1);
  // Counter value seen on the edge that shifts out the final bit.
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      sreg_q, sreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              listo_q, listo_d;

  // State register.
  always_ff @(posedge reloj) begin
    if (reset) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      listo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      listo_q <= listo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    listo_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (carga) begin
          sreg_d  = In;
          cnt_d   = '0;
          state_d = StShift;
        end
      end

      StShift: begin
        // carga and In are deliberately ignored here; the captured word is private.
        if (habilitar) begin
          sreg_d = {1'b0, sreg_q[N-1:1]};
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StIdle;
            listo_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded straight from state so they track it with no added latency.
  always_comb begin
    ocupado = (state_q == StShift);
    Sout    = ocupado & sreg_q[0];
    listo   = listo_q;
  end

endmodule

// File: tb/tb_reg_nbits_piso.sv
module tb_reg_nbits_piso;

  localparam int unsigned N = 4;

  logic         reloj;
  logic         reset;
  logic         carga;
  logic         habilitar;
  logic [N-1:0] In;
  logic         Sout;
  logic         ocupado;
  logic         listo;

  int vectors;
  int miscompares;

  reg_nbits_piso #(
    .N(N)
  ) dut (
    .reloj    (reloj),
    .reset    (reset),
    .carga    (carga),
    .habilitar(habilitar),
    .In       (In),
    .Sout     (Sout),
    .ocupado  (ocupado),
    .listo    (listo)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  // exp is {Sout, ocupado, listo}.
  task automatic chk(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {Sout, ocupado, listo};
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: {Sout,ocupado,listo} got %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    carga       = 1'b0;
    habilitar   = 1'b0;
    In          = '0;

    // Reset state.
    tick();
    chk("reset", 3'b000);
    // Reset beats carga on the same edge.
    carga = 1'b1; In = 4'b1011;
    tick();
    chk("reset_vs_carga", 3'b000);
    tick();
    chk("reset_vs_carga_2", 3'b000);

    // Idle hold with carga low.
    reset = 1'b0; carga = 1'b0; habilitar = 1'b1;
    tick();
    chk("idle_hold", 3'b000);

    // Basic transfer of 1011: Sout 1,1,0,1 then listo.
    carga = 1'b1; In = 4'b1011;
    tick(); chk("basic_b0", 3'b110);
    carga = 1'b0; In = 4'b0000;
    tick(); chk("basic_b1", 3'b110);
    tick(); chk("basic_b2", 3'b010);
    tick(); chk("basic_b3", 3'b110);
    tick(); chk("basic_listo", 3'b001);
    tick(); chk("basic_idle", 3'b000);

    // Stall for 3 cycles after the second bit.
    carga = 1'b1; In = 4'b1011;
    tick(); chk("stall_b0", 3'b110);
    carga = 1'b0;
    tick(); chk("stall_b1", 3'b110);
    habilitar = 1'b0;
    tick(); chk("stall_hold1", 3'b110);
    tick(); chk("stall_hold2", 3'b110);
    tick(); chk("stall_hold3", 3'b110);
    habilitar = 1'b1;
    tick(); chk("stall_b2", 3'b010);
    tick(); chk("stall_b3", 3'b110);
    tick(); chk("stall_listo", 3'b001);
    tick(); chk("stall_idle", 3'b000);

    // carga and a new In during SHIFT are ignored.
    carga = 1'b1; In = 4'b0110;
    tick(); chk("ign_b0", 3'b010);
    carga = 1'b1; In = 4'b1111;
    tick(); chk("ign_b1", 3'b110);
    carga = 1'b0;
    tick(); chk("ign_b2", 3'b110);
    tick(); chk("ign_b3", 3'b010);
    tick(); chk("ign_listo", 3'b001);
    tick(); chk("ign_idle", 3'b000);

    // carga held high: 1,0,0,1, idle/listo, repeated.
    carga = 1'b1; In = 4'b1001;
    for (int w = 0; w < 2; w++) begin
      tick(); chk("cont_b0", 3'b110);
      tick(); chk("cont_b1", 3'b010);
      tick(); chk("cont_b2", 3'b010);
      tick(); chk("cont_b3", 3'b110);
      tick(); chk("cont_listo", 3'b001);
    end
    carga = 1'b0;
    tick(); chk("cont_idle", 3'b000);

    // Reset after the second shift edge aborts without listo.
    carga = 1'b1; In = 4'b1011;
    tick(); chk("abort_b0", 3'b110);
    carga = 1'b0;
    tick(); chk("abort_b1", 3'b110);
    tick(); chk("abort_b2", 3'b010);
    reset = 1'b1;
    tick(); chk("abort_reset", 3'b000);
    reset = 1'b0;
    tick(); chk("abort_no_listo", 3'b000);

    // Fresh transfer of 0011 after abort: 1,1,0,0.
    carga = 1'b1; In = 4'b0011;
    tick(); chk("fresh_b0", 3'b110);
    carga = 1'b0;
    tick(); chk("fresh_b1", 3'b110);
    tick(); chk("fresh_b2", 3'b010);
    tick(); chk("fresh_b3", 3'b010);
    tick(); chk("fresh_listo", 3'b001);
    tick(); chk("fresh_idle", 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
